// File: rtl/rv_pkg.sv
// Shared definitions for the instruction fetch unit: widths, the halt
// sentinel word, the fetch FSM state type and the pc legality check.
package rv_pkg;

    localparam int XLEN    = 64;
    localparam int INSTR_W = 32;

    // An all-zero word marks the end of a program and stops fetching.
    localparam logic [INSTR_W-1:0] HALT_WORD = 32'h0000_0000;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FETCH = 2'd1,
        VALID = 2'd2,
        HALT  = 2'd3
    } fetch_state_e;

    // A pc is unusable when it is not word aligned or lies beyond the
    // last word of a memory holding 'depth' instructions.
    function automatic logic pc_fault(input logic [XLEN-1:0] pc,
                                      input int unsigned     depth);
        return (pc[1:0] != 2'b00) || (pc >= (XLEN'(depth) << 2));
    endfunction

endpackage

// File: rtl/instr_fetch_if.sv
// Load, issue and redirect signals between the fetch unit and its
// processor / loader. The fetch unit uses the master side.
interface instr_fetch_if #(
    parameter int DEPTH = 64
);
    import rv_pkg::*;

    logic                     load_en;
    logic [$clog2(DEPTH)-1:0] load_addr;
    logic [INSTR_W-1:0]       load_data;
    logic                     start;
    logic [INSTR_W-1:0]       instruction;
    logic                     instr_valid;
    logic                     instr_ready;
    logic [XLEN-1:0]          pc_out;
    logic                     redirect_valid;
    logic [XLEN-1:0]          redirect_pc;
    logic                     halted;
    logic                     fetch_error;

    modport master (
        input  load_en, load_addr, load_data, start,
        input  instr_ready, redirect_valid, redirect_pc,
        output instruction, instr_valid, pc_out, halted, fetch_error
    );

    modport slave (
        output load_en, load_addr, load_data, start,
        output instr_ready, redirect_valid, redirect_pc,
        input  instruction, instr_valid, pc_out, halted, fetch_error
    );

endinterface

// File: rtl/instr_mem.sv
// Local instruction store: one synchronous write port, one combinational
// read port. Contents are deliberately not reset.
module instr_mem
    import rv_pkg::*;
#(
    parameter int DEPTH = 64
) (
    input  logic                     clk,
    input  logic                     wr_en_i,
    input  logic [$clog2(DEPTH)-1:0] wr_addr_i,
    input  logic [INSTR_W-1:0]       wr_data_i,
    input  logic [$clog2(DEPTH)-1:0] rd_addr_i,
    output logic [INSTR_W-1:0]       rd_data_o
);

    logic [INSTR_W-1:0] mem_q [DEPTH];

    // Store a loaded word on the clock edge when the loader enables it.
    always_ff @(posedge clk) begin
        if (wr_en_i) begin
            mem_q[wr_addr_i] <= wr_data_i;
        end
    end

    assign rd_data_o = mem_q[rd_addr_i];

endmodule

// File: rtl/instr_fetch.sv
// Instruction fetch unit: sequences the pc through local memory, presents
// words with a valid/ready handshake, follows redirects and halts on a
// zero word or an illegal pc.
module instr_fetch
    import rv_pkg::*;
#(
    parameter int              DEPTH    = 64,
    parameter logic [XLEN-1:0] RESET_PC = 64'h0
) (
    input  logic          clk,
    input  logic          reset,
    instr_fetch_if.master bus
);

    localparam int AW = $clog2(DEPTH);

    fetch_state_e       state_q, state_d;
    logic [XLEN-1:0]    pc_q, pc_d;
    logic [XLEN-1:0]    pc_out_q, pc_out_d;
    logic [INSTR_W-1:0] instr_q, instr_d;
    logic               valid_q, valid_d;
    logic               err_q, err_d;

    logic [XLEN:0]      seq_sum;
    logic [XLEN-1:0]    seq_pc;
    logic               seq_wrap;
    logic [AW-1:0]      rd_addr;
    logic [INSTR_W-1:0] rd_data;
    logic               mem_wr_en;
    logic               start_ok;

    // The sequential successor carries one extra bit so a wrap past 2^64
    // is visible and can be treated as out of range.
    assign seq_sum  = {1'b0, pc_q} + {{XLEN{1'b0}}, 1'b0} + (XLEN+1)'(4);
    assign seq_pc   = seq_sum[XLEN-1:0];
    assign seq_wrap = seq_sum[XLEN];

    // In VALID the next word is read ahead so an accepted word is replaced
    // in the same cycle; in FETCH the current pc is read.
    assign rd_addr   = (state_q == VALID) ? seq_pc[AW+1:2] : pc_q[AW+1:2];
    assign mem_wr_en = bus.load_en && ((state_q == IDLE) || (state_q == HALT));
    assign start_ok  = bus.start && !bus.load_en;

    instr_mem #(
        .DEPTH (DEPTH)
    ) u_mem (
        .clk       (clk),
        .wr_en_i   (mem_wr_en),
        .wr_addr_i (bus.load_addr),
        .wr_data_i (bus.load_data),
        .rd_addr_i (rd_addr),
        .rd_data_o (rd_data)
    );

    // State, pc and issue registers; reset clears everything asynchronously.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q  <= IDLE;
            pc_q     <= RESET_PC;
            pc_out_q <= '0;
            instr_q  <= '0;
            valid_q  <= 1'b0;
            err_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            pc_q     <= pc_d;
            pc_out_q <= pc_out_d;
            instr_q  <= instr_d;
            valid_q  <= valid_d;
            err_q    <= err_d;
        end
    end

    // Next-state and datapath decisions; redirect outranks ready in VALID.
    always_comb begin
        state_d  = state_q;
        pc_d     = pc_q;
        pc_out_d = pc_out_q;
        instr_d  = instr_q;
        valid_d  = valid_q;
        err_d    = err_q;
        case (state_q)
            IDLE: begin
                if (start_ok) begin
                    pc_d    = RESET_PC;
                    state_d = FETCH;
                end
            end
            FETCH: begin
                valid_d = 1'b0;
                if (pc_fault(pc_q, DEPTH)) begin
                    err_d   = 1'b1;
                    state_d = HALT;
                end else if (rd_data == HALT_WORD) begin
                    err_d   = 1'b0;
                    state_d = HALT;
                end else begin
                    instr_d  = rd_data;
                    pc_out_d = pc_q;
                    valid_d  = 1'b1;
                    state_d  = VALID;
                end
            end
            VALID: begin
                if (bus.redirect_valid) begin
                    valid_d = 1'b0;
                    if (pc_fault(bus.redirect_pc, DEPTH)) begin
                        err_d   = 1'b1;
                        state_d = HALT;
                    end else begin
                        pc_d    = bus.redirect_pc;
                        state_d = FETCH;
                    end
                end else if (bus.instr_ready) begin
                    if (seq_wrap || pc_fault(seq_pc, DEPTH)) begin
                        valid_d = 1'b0;
                        err_d   = 1'b1;
                        state_d = HALT;
                    end else if (rd_data == HALT_WORD) begin
                        valid_d = 1'b0;
                        err_d   = 1'b0;
                        state_d = HALT;
                    end else begin
                        pc_d     = seq_pc;
                        pc_out_d = seq_pc;
                        instr_d  = rd_data;
                    end
                end
            end
            HALT: begin
                valid_d = 1'b0;
                if (start_ok) begin
                    err_d   = 1'b0;
                    pc_d    = RESET_PC;
                    state_d = FETCH;
                end
            end
            default: begin
                valid_d = 1'b0;
                state_d = IDLE;
            end
        endcase
    end

    assign bus.instruction = instr_q;
    assign bus.instr_valid = valid_q;
    assign bus.pc_out      = pc_out_q;
    assign bus.halted      = (state_q == HALT);
    assign bus.fetch_error = err_q;

endmodule

// File: doc/instr_fetch.md
INSTR_FETCH -- requirements
Module: instr_fetch

Interface
REQ-001 The block SHALL have parameter DEPTH, default 64, meaning the number of 32-bit instruction words in local memory (power of two).
REQ-002 The block SHALL have parameter RESET_PC, default 64'h0, meaning the byte address fetched first after start.
REQ-003 The block SHALL have port clk  input  1  single clock; all state changes on the rising edge.
REQ-004 The block SHALL have port reset  input  1  asynchronous, active-low reset.
REQ-005 The block SHALL have port load_en  input  1  writes load_data into memory this cycle.
REQ-006 The block SHALL have port load_addr  input  log2(DEPTH)  word index for the load.
REQ-007 The block SHALL have port load_data  input  32  instruction word to store.
REQ-008 The block SHALL have port start  input  1  begins fetching from RESET_PC.
REQ-009 The block SHALL have port instruction  output  32  instruction word presented to the processor.
REQ-010 The block SHALL have port instr_valid  output  1  instruction and pc_out are valid.
REQ-011 The block SHALL have port instr_ready  input  1  processor accepts the current instruction.
REQ-012 The block SHALL have port pc_out  output  64  byte address of the current instruction.
REQ-013 The block SHALL have port redirect_valid  input  1  processor requests a branch or jump.
REQ-014 The block SHALL have port redirect_pc  input  64  target byte address of the redirect.
REQ-015 The block SHALL have port halted  output  1  the fetch unit has stopped.
REQ-016 The block SHALL have port fetch_error  output  1  the halt was caused by a misaligned or out-of-range pc.

Function
REQ-017 The FSM SHALL have exactly these states: IDLE, FETCH, VALID and HALT.
REQ-018 In IDLE, start SHALL set pc to RESET_PC and enter FETCH on the next cycle.
REQ-019 A start in the same cycle as load_en SHALL be ignored.
REQ-020 In FETCH, the unit SHALL register mem[pc[log2(DEPTH)+1:2]] into instruction and pc into pc_out, assert instr_valid, and enter VALID, giving one cycle of latency from FETCH to valid.
REQ-021 In VALID with instr_ready=0, instruction, pc_out and instr_valid SHALL hold stable.
REQ-022 In VALID with instr_ready=1 and redirect_valid=0, the unit SHALL set pc to pc+4 and load the next word in the same cycle, so instr_valid stays 1 (back-to-back issue, no bubble).
REQ-023 redirect_valid SHALL take priority over instr_ready: the unit sets pc to redirect_pc, deasserts instr_valid for one cycle and enters FETCH.
REQ-024 A redirect_valid in IDLE or HALT SHALL be ignored.
REQ-025 A redirect_pc with bits [1:0] not equal to 0 SHALL cause entry to HALT with fetch_error=1.
REQ-026 A pc (sequential or redirected) >= DEPTH*4 SHALL cause entry to HALT with fetch_error=1 and instr_valid=0, and the word SHALL not be issued.
REQ-027 A fetched word equal to 32'h00000000 SHALL not be issued and SHALL cause entry to HALT with fetch_error=0.
REQ-028 In HALT, halted=1 and instr_valid=0.
REQ-029 In HALT, start SHALL clear fetch_error and restart from RESET_PC as in IDLE.
REQ-030 load_en SHALL write memory only in IDLE or HALT and SHALL be ignored in FETCH or VALID.
REQ-031 Memory contents SHALL be undefined after power-up and SHALL not be cleared by reset.
REQ-032 pc arithmetic SHALL be 64-bit unsigned; a wrap past 2^64 SHALL be treated as out-of-range per REQ-026.

Reset
REQ-033 Asserting reset low SHALL force, asynchronously, state=IDLE, pc=RESET_PC, pc_out=0, instruction=0, instr_valid=0, halted=0 and fetch_error=0.
REQ-034 Reset asserted mid-VALID SHALL drop instr_valid immediately without waiting for a clock edge.
REQ-035 The first fetch after reset release SHALL require a new start pulse.

Structure
REQ-036 The FSM state enum, XLEN=64, INSTR_W=32 and the HALT_WORD constant (32'h0) SHALL reside in the shared rv_pkg package.
REQ-037 The memory array with its write port and combinational read SHALL be a separate sub-module, instr_mem.
REQ-038 The FSM and pc datapath SHALL reside in instr_fetch.

Verification
REQ-039 Load 00A00093, 01408113, 002081B3 at words 0-2, then pulse start with instr_ready=1 -> words issued back-to-back with pc_out 0, 4, 8, then HALT (zero word) with fetch_error=0.
REQ-040 Hold instr_ready=0 for 5 cycles while word 0 is valid -> instruction=00A00093 and pc_out=0 held stable for all 5 cycles, then pc_out=4 one cycle after ready rises.
REQ-041 Apply redirect_valid with redirect_pc=0x10 while instr_ready=1 -> one bubble cycle, then pc_out=0x10 and instruction=mem[4].
REQ-042 Apply redirect_pc=0x102 -> halted=1 and fetch_error=1; apply redirect_pc=0x100 with DEPTH=64 -> halted=1 and fetch_error=1.
REQ-043 Apply load_en during VALID -> memory unchanged; start together with load_en in IDLE -> start ignored.
REQ-044 Drive reset low mid-VALID between clock edges -> instr_valid=0 immediately; after release, start reissues pc_out=0.
